func_eval_pipe: RTL and testbench

FUNC_EVAL_PIPE -- requirements
Module: func_eval_pipe

---
 rtl/func_eval_pipe.sv | 47 ++++
 tb/tb_func_eval_pipe.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/func_eval_pipe.sv
// func_eval_pipe: one-deep registered bitwise function stage with valid/ready handshake.
// Optional saturating hit counter when FUNC_EVAL_HIT_COUNT_EN is defined.
module func_eval_pipe #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [1:0]       mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic [CNT_W-1:0] hit_count
);
  typedef enum logic {EMPTY, FULL} state_t;
  state_t state;
  logic accept;
  logic [WIDTH-1:0] f;
  assign in_ready  = (state == EMPTY) | out_ready;
  assign accept    = in_valid & in_ready;
  assign out_valid = state == FULL;
  always_comb f = mode == 2'b00 ? ~x & y :
                  mode == 2'b01 ? x & ~y :
                  mode == 2'b10 ? x ^ y  : ~(x | y);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= EMPTY;
      s     <= '0;
    end else begin
      if (accept) s <= f;
      state <= accept ? FULL : out_ready ? EMPTY : state;
    end
  end
`ifdef FUNC_EVAL_HIT_COUNT_EN
  // counted at accept so downstream stalls never affect the tally
  always_ff @(posedge clk or posedge reset) begin
    if (reset) hit_count <= '0;
    else if (accept && f != '0 && hit_count != '1) hit_count <= hit_count + 1'b1;
  end
`else
  assign hit_count = '0;
`endif
endmodule

// File: tb/tb_func_eval_pipe.sv
// tb_func_eval_pipe: directed bench with a per-cycle reference model for two configurations.
module tb_func_eval_pipe;
`ifdef FUNC_EVAL_HIT_COUNT_EN
  localparam bit HC = 1;
`else
  localparam bit HC = 0;
`endif
  logic clk = 0, reset = 0;
  logic iv4 = 0, or4 = 1, ir4, ov4;
  logic [3:0] x4 = 0, y4 = 0, s4;
  logic [1:0] md4 = 0;
  logic [7:0] hc4;
  logic iv1 = 0, or1 = 1, ir1, ov1;
  logic [0:0] x1 = 0, y1 = 0, s1;
  logic [1:0] md1 = 0;
  logic [1:0] hc1;
  int checks = 0, failures = 0;

  func_eval_pipe #(.WIDTH(4), .CNT_W(8)) d4 (
    .clk(clk), .reset(reset), .in_valid(iv4), .in_ready(ir4), .x(x4), .y(y4), .mode(md4),
    .out_valid(ov4), .out_ready(or4), .s(s4), .hit_count(hc4));
  func_eval_pipe #(.WIDTH(1), .CNT_W(2)) d1 (
    .clk(clk), .reset(reset), .in_valid(iv1), .in_ready(ir1), .x(x1), .y(y1), .mode(md1),
    .out_valid(ov1), .out_ready(or1), .s(s1), .hit_count(hc1));

  always #5 clk = ~clk;

  function automatic logic [31:0] fe(logic [1:0] m, logic [31:0] a, logic [31:0] b, int w);
    logic [31:0] r;
    case (m)
      2'd0: r = ~a & b;
      2'd1: r = a & ~b;
      2'd2: r = a ^ b;
      default: r = ~(a | b);
    endcase
    return r & ((32'd1 << w) - 1);
  endfunction

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h at %0t", n, a, e, $time);
    end
  endtask

  // reference model: one-slot buffer, saturating hit tally
  logic m4_full, m1_full;
  logic [31:0] m4_s, m1_s;
  int m4_cnt, m1_cnt;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m4_full <= 0; m4_s <= 0; m4_cnt <= 0;
      m1_full <= 0; m1_s <= 0; m1_cnt <= 0;
    end else begin
      if (iv4 && (!m4_full || or4)) begin
        m4_full <= 1;
        m4_s <= fe(md4, 32'(x4), 32'(y4), 4);
        if (HC && fe(md4, 32'(x4), 32'(y4), 4) != 0) m4_cnt <= (m4_cnt < 255) ? m4_cnt + 1 : 255;
      end else if (or4) m4_full <= 0;
      if (iv1 && (!m1_full || or1)) begin
        m1_full <= 1;
        m1_s <= fe(md1, 32'(x1), 32'(y1), 1);
        if (HC && fe(md1, 32'(x1), 32'(y1), 1) != 0) m1_cnt <= (m1_cnt < 3) ? m1_cnt + 1 : 3;
      end else if (or1) m1_full <= 0;
    end
  end

  always @(negedge clk) begin
    chk("m4_out_valid", 32'(ov4), 32'(m4_full));
    chk("m4_in_ready", 32'(ir4), 32'(!m4_full || or4));
    chk("m4_s", 32'(s4), m4_s);
    chk("m4_hit", 32'(hc4), 32'(m4_cnt));
    chk("m1_out_valid", 32'(ov1), 32'(m1_full));
    chk("m1_in_ready", 32'(ir1), 32'(!m1_full || or1));
    chk("m1_s", 32'(s1), m1_s);
    chk("m1_hit", 32'(hc1), 32'(m1_cnt));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    iv4 = 0; iv1 = 0; or4 = 1; or1 = 1;
    @(posedge clk);
    #2 reset = 1;
    #2 reset = 0;
    chk("rst_in_ready", 32'(ir4), 1);
  endtask

  initial begin
    #1 reset = 1;
    #1;
    chk("init_out_valid", 32'(ov4), 0);
    chk("init_s", 32'(s4), 0);
    chk("init_hit", 32'(hc4), 0);
    chk("init_in_ready", 32'(ir4), 1);
    #10 reset = 0;
    // single accept, legacy function
    do_reset();
    iv4 = 1; x4 = 4'h0; y4 = 4'hA; md4 = 2'b00; or4 = 1;
    tick();
    chk("single_ov", 32'(ov4), 1);
    chk("single_s", 32'(s4), 32'hA);
    chk("single_hit", 32'(hc4), HC ? 1 : 0);
    iv4 = 0;
    tick();
    chk("single_drain_ov", 32'(ov4), 0);
    chk("single_hold_s", 32'(s4), 32'hA);
    // 1-bit legacy truth table, streamed
    do_reset();
    iv1 = 1; md1 = 2'b00; or1 = 1;
    for (int i = 0; i < 4; i++) begin
      logic [3:0] tt;
      tt = 4'b0010;
      x1 = 1'(i >> 1); y1 = 1'(i);
      tick();
      chk("legacy_1bit_s", 32'(s1), 32'(tt[i]));
      chk("legacy_1bit_ov", 32'(ov1), 1);
    end
    iv1 = 0;
    // backpressure
    do_reset();
    iv4 = 1; x4 = 4'hF; y4 = 4'h0; md4 = 2'b01;
    tick();
    or4 = 0;
    for (int i = 0; i < 3; i++) begin
      x4 = 4'(i + 1); y4 = 4'(i * 5);
      #1;
      chk("bp_in_ready", 32'(ir4), 0);
      tick();
      chk("bp_s", 32'(s4), 32'hF);
      chk("bp_ov", 32'(ov4), 1);
      chk("bp_hit", 32'(hc4), HC ? 1 : 0);
    end
    x4 = 4'h3; y4 = 4'h1; or4 = 1;
    tick();
    chk("bp_release_s", 32'(s4), 32'h2);
    chk("bp_release_hit", 32'(hc4), HC ? 2 : 0);
    // streaming zero results
    do_reset();
    iv4 = 1; or4 = 1; md4 = 2'b10;
    for (int i = 0; i < 8; i++) begin
      x4 = 4'(i * 3); y4 = 4'(i * 3);
      tick();
      chk("stream_ov", 32'(ov4), 1);
      chk("stream_s", 32'(s4), 0);
      chk("stream_hit", 32'(hc4), 0);
    end
    iv4 = 0;
    // saturation on the 2-bit counter
    do_reset();
    iv1 = 1; or1 = 1; md1 = 2'b10; x1 = 1; y1 = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("sat_hit", 32'(hc1), HC ? (i < 3 ? i + 1 : 3) : 0);
    end
    iv1 = 0;
    // async reset between edges while full
    do_reset();
    iv4 = 1; x4 = 4'h5; y4 = 4'h0; md4 = 2'b01;
    tick();
    iv4 = 0; or4 = 0;
    chk("async_pre_ov", 32'(ov4), 1);
    #1 reset = 1;
    #1 reset = 0;
    #1;
    chk("async_ov", 32'(ov4), 0);
    chk("async_s", 32'(s4), 0);
    chk("async_hit", 32'(hc4), 0);
    chk("async_in_ready", 32'(ir4), 1);
    or4 = 1;
    tick();
    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
